// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg: M-extension op codes, FSM encodings and sign helper.
package ex_muldiv_unit_pkg;
   localparam int MULDIV_XLEN = 32;
   localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
   localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
   localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
   localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
   localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
   localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
   localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
   localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;
   typedef enum logic [1:0] {
      MULDIV_STATE_IDLE = 2'd0,
      MULDIV_STATE_MUL  = 2'd1,
      MULDIV_STATE_DIV  = 2'd2,
      MULDIV_STATE_DONE = 2'd3
   } muldiv_state_e;
   function automatic logic [MULDIV_XLEN-1:0] neg_if(input logic n, input logic [MULDIV_XLEN-1:0] v);
      return n ? -v : v;
   endfunction
endpackage

// File: rtl/ex_muldiv_unit_divider_core.sv
// muldiv_divider_core: unsigned restoring divider, one quotient bit per cycle, MSB first.
module muldiv_divider_core #(
   parameter int XLEN  = 32,
   parameter int STEPS = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);
   localparam int CW = $clog2(STEPS);
   logic            busy_q, done_q, fits;
   logic [CW-1:0]   cnt_q;
   logic [XLEN-1:0] quo_q, rem_q, dvs_q;
   logic [XLEN:0]   shifted, trial;
   // quotient register doubles as the dividend shifter
   always_comb begin
      shifted = {rem_q, quo_q[XLEN-1]};
      trial   = shifted - {1'b0, dvs_q};
      fits    = !trial[XLEN];
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
      end else if (start) begin
         busy_q <= 1'b1;
         done_q <= 1'b0;
         cnt_q  <= '0;
         quo_q  <= dividend;
         rem_q  <= '0;
         dvs_q  <= divisor;
      end else if (busy_q) begin
         rem_q  <= fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
         quo_q  <= {quo_q[XLEN-2:0], fits};
         cnt_q  <= cnt_q + 1'b1;
         busy_q <= cnt_q != CW'(STEPS-1);
         done_q <= cnt_q == CW'(STEPS-1);
      end else begin
         done_q <= 1'b0;
      end
   end
   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide for the EX stage.
// Stalls the pipeline while busy and presents a registered result in DONE.
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int DIV_STEPS = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            valid,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            stall,
   output logic            result_valid,
   output logic [XLEN-1:0] result
);
   muldiv_state_e state_q, state_d;
   logic [2:0]    op_q;
   logic [XLEN-1:0] a_q, b_q, result_q, result_d;
   logic a_neg_q, b_neg_q, result_valid_q;
   logic sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf, special;
   logic dv_start, dv_busy, dv_done;
   logic [XLEN-1:0] dv_quo, dv_rem, special_res, mul_res, div_res;
   logic signed [2*XLEN-1:0] ma, mb, prod;
   always_comb begin
      sgn_a       = op != MULDIV_OP_MULHU && op != MULDIV_OP_DIVU && op != MULDIV_OP_REMU;
      sgn_b       = sgn_a && op != MULDIV_OP_MULHSU;
      a_neg       = sgn_a && rs1_data[XLEN-1];
      b_neg       = sgn_b && rs2_data[XLEN-1];
      div_zero    = rs2_data == '0;
      div_ovf     = sgn_b && op[2] && rs1_data == {1'b1, {(XLEN-1){1'b0}}} && rs2_data == '1;
      special     = op[2] && (div_zero || div_ovf);
      special_res = div_zero ? (op[1] ? rs1_data : '1) : (op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
      dv_start    = state_q == MULDIV_STATE_IDLE && valid && !flush && op[2] && !special && !dv_busy;
      // sign-extending to 2*XLEN makes one signed multiply cover all four variants
      ma          = {{XLEN{a_neg_q}}, a_q};
      mb          = {{XLEN{b_neg_q}}, b_q};
      prod        = ma * mb;
      mul_res     = op_q == MULDIV_OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      div_res     = op_q[1] ? neg_if(a_neg_q, dv_rem) : neg_if(a_neg_q ^ b_neg_q, dv_quo);
      result_d    = state_q == MULDIV_STATE_IDLE ? special_res :
                    state_q == MULDIV_STATE_MUL  ? mul_res : div_res;
   end
   muldiv_divider_core #(.XLEN(XLEN), .STEPS(DIV_STEPS)) u_div (
      .clock    (clock),
      .reset    (reset || flush),
      .start    (dv_start),
      .dividend (neg_if(a_neg, rs1_data)),
      .divisor  (neg_if(b_neg, rs2_data)),
      .busy     (dv_busy),
      .done     (dv_done),
      .quotient (dv_quo),
      .remainder(dv_rem)
   );
   always_ff @(posedge clock) begin
      if (reset || flush) state_q <= MULDIV_STATE_IDLE;
      else                state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         MULDIV_STATE_IDLE: if (valid) state_d = !op[2] ? MULDIV_STATE_MUL : special ? MULDIV_STATE_DONE : MULDIV_STATE_DIV;
         MULDIV_STATE_MUL:  state_d = MULDIV_STATE_DONE;
         MULDIV_STATE_DIV:  state_d = dv_done ? MULDIV_STATE_DONE : MULDIV_STATE_DIV;
         default:           state_d = MULDIV_STATE_IDLE;
      endcase
   end
   always_comb begin
      stall = valid && state_q != MULDIV_STATE_DONE && !flush;
   end
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         op_q           <= '0;
         a_q            <= '0;
         b_q            <= '0;
         a_neg_q        <= 1'b0;
         b_neg_q        <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         result_valid_q <= state_d == MULDIV_STATE_DONE;
         if (state_d == MULDIV_STATE_DONE) result_q <= result_d;
         if (state_q == MULDIV_STATE_IDLE && valid) begin
            op_q    <= op;
            a_q     <= rs1_data;
            b_q     <= rs2_data;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
         end
      end
   end
   assign result_valid = result_valid_q;
   assign result       = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and randomized checks of ex_muldiv_unit against an arithmetic model.
module tb_ex_muldiv_unit;
   logic        clock, reset, flush, valid, stall, result_valid;
   logic [2:0]  op;
   logic [31:0] rs1_data, rs2_data, result;
   int checks = 0;
   int errors = 0;

   ex_muldiv_unit dut (
      .clock(clock), .reset(reset), .flush(flush), .valid(valid), .op(op),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .stall(stall), .result_valid(result_valid), .result(result)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (o)
         3'd0, 3'd1: r = sa * sb;
         3'd2:       r = sa * ub;
         3'd3:       r = ua * ub;
         3'd4:       r = (b == 0) ? -64'sd1 : sa / sb;
         3'd5:       r = (b == 0) ? -64'sd1 : ua / ub;
         3'd6:       r = (b == 0) ? ua : sa % sb;
         default:    r = (b == 0) ? ua : ua % ub;
      endcase
      return (o == 3'd1 || o == 3'd2 || o == 3'd3) ? r[63:32] : r[31:0];
   endfunction

   function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      if (o < 3'd4) return 2;
      if (b == 0) return 1;
      if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return $urandom_range(0, 40);
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         4:       return -$urandom_range(1, 40);
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
      int n;
      @(posedge clock); #1;
      valid = 1'b1; op = o; rs1_data = a; rs2_data = b;
      n = 0;
      @(negedge clock);
      chk({tag, " rv_before"}, {31'd0, result_valid}, 32'd0);
      while (stall && n < 200) begin
         n++;
         @(negedge clock);
      end
      chk({tag, " stall_cycles"}, n, ref_lat(o, a, b));
      chk({tag, " result_valid"}, {31'd0, result_valid}, 32'd1);
      chk({tag, " result"}, result, ref_res(o, a, b));
   endtask

   task automatic go_idle();
      @(posedge clock); #1;
      valid = 1'b0;
   endtask

   initial begin
      int rv_seen;
      reset = 1'b1; flush = 1'b0; valid = 1'b0; op = '0; rs1_data = '0; rs2_data = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("reset stall", {31'd0, stall}, 32'd0);
      chk("reset result_valid", {31'd0, result_valid}, 32'd0);
      chk("reset result", result, 32'd0);

      run_op(3'd0, 32'd7, 32'hFFFF_FFFA, "MUL 7*-6");
      run_op(3'd1, 32'd7, 32'hFFFF_FFFA, "MULH 7*-6");
      run_op(3'd3, 32'd7, 32'hFFFF_FFFA, "MULHU 7*-6");
      go_idle();
      run_op(3'd4, -32'd20, 32'd3, "DIV -20/3");
      run_op(3'd6, -32'd20, 32'd3, "REM -20/3");
      run_op(3'd5, 32'd20, 32'd3, "DIVU 20/3");
      run_op(3'd7, 32'd20, 32'd3, "REMU 20/3");
      run_op(3'd5, 32'h1234, 32'd0, "DIVU by0");
      run_op(3'd7, 32'h1234, 32'd0, "REMU by0");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV ovf");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "REM ovf");
      go_idle();

      // flush in the middle of a divide
      @(posedge clock); #1;
      valid = 1'b1; op = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd7;
      repeat (11) @(posedge clock);
      #1 flush = 1'b1;
      @(negedge clock);
      chk("flush stall", {31'd0, stall}, 32'd0);
      @(posedge clock); #1;
      flush = 1'b0; valid = 1'b0;
      @(negedge clock);
      chk("post-flush stall", {31'd0, stall}, 32'd0);
      chk("post-flush result_valid", {31'd0, result_valid}, 32'd0);
      rv_seen = 0;
      repeat (40) begin
         @(negedge clock);
         if (result_valid) rv_seen++;
      end
      chk("flushed op never completes", rv_seen, 0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2, "MULHSU -1*2");
      go_idle();

      // reset in the middle of a divide, then back-to-back ops
      @(posedge clock); #1;
      valid = 1'b1; op = 3'd5; rs1_data = 32'd999; rs2_data = 32'd4;
      repeat (15) @(posedge clock);
      #1 reset = 1'b1; valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("midreset result", result, 32'd0);
      chk("midreset result_valid", {31'd0, result_valid}, 32'd0);
      run_op(3'd5, 32'd100, 32'd7, "DIVU 100/7");
      run_op(3'd0, 32'd3, 32'd5, "MUL 3*5");
      go_idle();
      @(negedge clock);
      chk("pulse ends", {31'd0, result_valid}, 32'd0);

      for (int i = 0; i < 60; i++) begin
         logic [2:0] o;
         o = 3'($urandom_range(0, 7));
         run_op(o, pick(), pick(), $sformatf("rand%0d op%0d", i, o));
         if ($urandom_range(0, 3) == 0) go_idle();
      end
      go_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline registers (rs1/rs2 data plus decoded M-op).
- Holds the pipeline by driving the ID/EX and upstream stall inputs while an operation is in progress.
- Presents a registered 32-bit result for one cycle, when the stall drops, for the EX/MEM register to capture.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- DIV_STEPS, 32, restoring-division iterations; must equal XLEN.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- flush  input  1  synchronous kill of the in-flight op (branch taken / trap).
- valid  input  1  EX holds an M-extension instruction; level signal, held while stall is high.
- op  input  3  funct3 code: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- rs1_data  input  XLEN  dividend / multiplicand.
- rs2_data  input  XLEN  divisor / multiplier.
- stall  output  1  combinational; high while valid and result not yet ready.
- result_valid  output  1  registered; high exactly in the DONE cycle.
- result  output  XLEN  registered result; meaningful only when result_valid is high.

Behaviour:
- States: IDLE, MUL, DIV, DONE. Encoded in 2 bits.
- stall = valid && (state != DONE) && !flush.
- Reset (any state, including mid-divide): state=IDLE, result=0, result_valid=0, step counter=0, internal operand/remainder/quotient registers=0.
- Flush has the same effect as reset on the state and registers, and takes priority over valid in the same cycle.

IDLE:
- With valid=1, latch op, operands and sign flags.
- op<4: go to MUL.
- op>=4 with rs2_data==0: go to DONE with the divide-by-zero result.
- DIV with rs1_data=0x80000000 and rs2_data=0xFFFFFFFF: go to DONE with the overflow result.
- Otherwise go to DIV with counter=0.

MUL:
- Computes the 64-bit product of the operands after sign extension:
  - MUL and MULH: signed x signed.
  - MULHSU: signed rs1 x unsigned rs2.
  - MULHU: unsigned x unsigned.
- Registers product[31:0] for MUL, product[63:32] otherwise.
- Goes to DONE.

DIV:
- Unsigned restoring division on absolute values, one quotient bit per cycle, MSB first.
- After DIV_STEPS cycles (counter==31), apply signs and go to DONE:
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.

DONE:
- result_valid=1 and stall drops, so the pipeline advances this cycle.
- Next state is IDLE unconditionally. A back-to-back M-op is seen in IDLE on the following cycle.

Special results:
- Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = rs1_data.
- Overflow: DIV = 0x80000000; REM = 0.

Latency, with valid rising in cycle 0:
- MUL ops: stall high in cycles 0–1, DONE in cycle 2.
- DIV ops: stall high in cycles 0–33, DONE in cycle 34.
- Special cases: stall high in cycle 0, DONE in cycle 1.

Other rules:
- valid dropping mid-operation without flush is a protocol violation; the unit finishes the op anyway, and stall stays low because valid=0.
- Operand inputs are ignored outside IDLE.

Decomposition:
- Shared defines file (next to the BRANCH_*/ATOMIC_* constants): MULDIV_OP_* codes, MULDIV_STATE_* encodings.
- One sub-module: muldiv_divider_core.
  - Unsigned XLEN-bit restoring-division step engine with start/busy/done handshake and quotient/remainder outputs.
  - Sign handling and special cases stay in ex_muldiv_unit.

Test Plan:
- MUL 7 x 0xFFFFFFFA (-6): stall high 2 cycles, then result_valid=1 and result=0xFFFFFFD6; MULH gives 0xFFFFFFFF; MULHU gives 0x00000006.
- DIV -20/3: stall high 34 cycles, then result=0xFFFFFFFA (-6); REM gives 0xFFFFFFFE (-2); DIVU 20/3 gives 6; REMU 20/3 gives 2.
- DIVU 0x1234/0: 1 stall cycle, then result=0xFFFFFFFF; REMU 0x1234/0 gives 0x1234.
- DIV 0x80000000/0xFFFFFFFF: result=0x80000000 after 1 cycle; REM gives 0.
- Flush asserted at divide cycle 10: stall and result_valid low next cycle, state IDLE; a new MULHSU 0xFFFFFFFF x 2 then yields 0xFFFFFFFF.
- Reset asserted mid-divide, then back-to-back DIVU 100/7 and MUL 3x5: results 14 and 15, each result_valid pulse exactly 1 cycle.
